lsu_bus_ctrl: RTL and testbench
===============================

Name: lsu_bus_ctrl

Overview:
- Load/store unit that executes the memory side of the instruction decoder's control encodings.
- Consumes the decoder's store-size code (mem_write) and load-type code (reg_write), plus the ALU-computed address and the rs2 store data.
- Drives a word-wide data-memory bus with a req/ack handshake, stalls the core until the access completes, and returns aligned, sign- or zero-extended load data to write-back.

Parameters:
TIMEOUT, 255, maximum REQ cycles to wait for bus_ack before aborting with err (range 1..255)
XLEN, 32, data/address width

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
ld_en  in  1  current instruction is a load (WBsel selects memory)
ld_code  in  3  load type: 1=lw, 2=lb, 3=lh, 4=lbu, 5=lhu; any other code = lw
st_code  in  2  store size: 0=none, 1=sb, 2=sh, 3=sw
addr  in  XLEN  byte address from ALU
wdata  in  XLEN  store data (rs2)
stall  out  1  hold PC and pipeline registers
rdata  out  XLEN  extended load result, valid when rdata_valid=1
rdata_valid  out  1  one-cycle pulse, load result ready
err  out  1  one-cycle pulse: misaligned, conflicting, or timed-out access
bus_req  out  1  bus request
bus_we  out  1  1=write, 0=read
bus_addr  out  XLEN  word address ({addr[31:2],2'b00})
bus_be  out  4  byte enables
bus_wdata  out  XLEN  lane-replicated store data
bus_ack  in  1  bus completion; read data valid in the same cycle
bus_rdata  in  XLEN  read word

Behaviour:
- Reset (async): state=IDLE, timeout counter=0, and every output (stall, rdata, rdata_valid, err, bus_*) = 0.
- Reset asserted mid-REQ drops bus_req immediately, with no completion.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - An access is presented when ld_en=1 or st_code!=0.
  - stall is asserted combinationally in the same cycle.
  - Legal access: latch word address, bus_we, bus_be, lane-shifted wdata, ld_code and addr[1:0]; next state REQ.
  - Illegal access: no bus activity; next state DONE with err=1.
  - Illegal means misaligned (sh/lh/lhu with addr[0]=1; sw/lw with addr[1:0]!=0) or ld_en=1 together with st_code!=0.
- REQ:
  - bus_req=1; bus_addr, bus_we, bus_be and bus_wdata stay stable until ack. stall=1.
  - On bus_ack=1: capture bus_rdata; next state DONE.
  - Counter increments each REQ cycle without ack. If there is no ack on the TIMEOUT-th REQ cycle: next state DONE with err=1, bus_req drops.
- DONE (one cycle):
  - stall=0; bus_req=0.
  - rdata_valid=1 only for a successful load.
  - err as latched.
  - Next state IDLE unconditionally. Inputs seen in DONE belong to the retiring instruction and are never re-accepted.
- Minimum latency: 3 cycles (IDLE, REQ with ack, DONE); stall is high for 2 of them.
- Store lane rules:
  - sb: bus_be=4'b0001<<addr[1:0]; wdata[7:0] replicated into all 4 bytes.
  - sh: bus_be=4'b0011<<{addr[1],1'b0}; wdata[15:0] replicated into both halves.
  - sw: bus_be=4'b1111; wdata unchanged.
- Loads:
  - bus_be=4'b1111, bus_we=0.
  - Byte/halfword selected by the latched addr[1:0].
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes the full word.
- rdata holds its value until the next successful load.

Decomposition:
- Shared package lsu_pkg:
  - load codes LD_LW=1, LD_LB=2, LD_LH=3, LD_LBU=4, LD_LHU=5
  - store codes ST_NONE=0, ST_SB=1, ST_SH=2, ST_SW=3
  - FSM state encoding IDLE/REQ/DONE
- Sub-module: lsu_lane_align, purely combinational.
  - Store side: byte-enable and wdata replication.
  - Load side: byte/half extraction and sign/zero extension.
  - Shared with any future cache fill path.

Test Plan:
- sw addr=0x100, wdata=0xDEADBEEF, ack on the 3rd REQ cycle -> bus_addr=0x100, bus_be=4'b1111, bus_we=1, stall high 4 cycles, no rdata_valid, no err.
- sb addr=0x103, wdata=0x000000A5, immediate ack -> bus_addr=0x100, bus_be=4'b1000, bus_wdata=0xA5A5A5A5, stall high 2 cycles.
- lb addr=0x202, bus_rdata=0x12F45678 -> rdata=0xFFFFFFF4 with a 1-cycle rdata_valid in DONE; repeat as lbu -> 0x000000F4; lhu addr=0x202 -> 0x000012F4.
- lh addr=0x201 -> bus_req never asserted, stall high 1 cycle, err=1 in the following cycle, rdata unchanged.
- TIMEOUT=4, lw addr=0x40, bus_ack held 0 -> bus_req high exactly 4 cycles, then err=1 for 1 cycle, stall=0, rdata_valid=0.
- rst asserted in the 2nd REQ cycle of a sw -> bus_req=0 and stall=0 immediately; after release, lw addr=0x10 with ack completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: decoder load/store codes, FSM states
// and the access-legality rule used when an access is first presented.
package lsu_pkg;

  localparam int unsigned BE_W  = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] LD_LW  = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Misaligned for its size, or a load and a store claimed by the same instruction.
  function automatic logic access_illegal(input logic       ld,
                                          input logic [2:0] lc,
                                          input logic [1:0] sc,
                                          input logic [1:0] off);
    logic mis_ld;
    logic mis_st;
    if (lc == LD_LB || lc == LD_LBU)      mis_ld = 1'b0;
    else if (lc == LD_LH || lc == LD_LHU) mis_ld = off[0];
    else                                  mis_ld = (off != 2'b00);
    case (sc)
      ST_SH:   mis_st = off[0];
      ST_SW:   mis_st = (off != 2'b00);
      default: mis_st = 1'b0;
    endcase
    return (ld && sc != ST_NONE) || (ld && mis_ld) || (!ld && mis_st);
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Word-wide data-memory bus with req/ack handshake; read data valid with ack.
interface lsu_bus_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      st_code,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] wdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] st_data,
  input  logic [2:0]      ld_code,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rword,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be      = 4'b1111;
    st_data = wdata;
    case (st_code)
      ST_SB: begin
        be      = 4'b0001 << st_off;
        st_data = {(XLEN/8){wdata[7:0]}};
      end
      ST_SH: begin
        be      = 4'b0011 << {st_off[1], 1'b0};
        st_data = {(XLEN/16){wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_sel = rword[{ld_off, 3'b000} +: 8];
  assign half_sel = rword[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = rword;
    case (ld_code)
      LD_LB:   ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  ld_data = {{(XLEN-8){1'b0}}, byte_sel};
      LD_LH:   ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_LHU:  ld_data = {{(XLEN-16){1'b0}}, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: runs one memory access per instruction over the req/ack bus,
// stalls the core meanwhile and returns extended load data to write-back.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned XLEN    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [2:0]        ld_code,
  input  logic [1:0]        st_code,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              stall,
  output logic [XLEN-1:0]   rdata,
  output logic              rdata_valid,
  output logic              err,
  lsu_bus_ctrl_if.master    bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ld_code_q;
  logic [1:0]       off_q;
  logic             is_ld_q;

  logic [BE_W-1:0]  be_st;
  logic [XLEN-1:0]  wdata_st;
  logic [XLEN-1:0]  ld_data;
  logic             access;
  logic             illegal;
  logic             timeout_hit;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .st_code (st_code),
    .st_off  (addr[1:0]),
    .wdata   (wdata),
    .be      (be_st),
    .st_data (wdata_st),
    .ld_code (ld_code_q),
    .ld_off  (off_q),
    .rword   (bus.rdata),
    .ld_data (ld_data)
  );

  assign access      = ld_en | (st_code != ST_NONE);
  assign illegal     = access_illegal(ld_en, ld_code, st_code, addr[1:0]);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Stall must rise in the same cycle the access is presented; reset forces it low.
  assign stall = ~rst & ((state == REQ) | ((state == IDLE) & access));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ld_code_q   <= '0;
      off_q       <= '0;
      is_ld_q     <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      bus.req     <= 1'b0;
      bus.we      <= 1'b0;
      bus.addr    <= '0;
      bus.be      <= '0;
      bus.wdata   <= '0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (illegal) begin
              state <= DONE;
              err   <= 1'b1;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              bus.req   <= 1'b1;
              bus.we    <= ~ld_en;
              bus.addr  <= {addr[XLEN-1:2], 2'b00};
              bus.be    <= ld_en ? 4'b1111 : be_st;
              bus.wdata <= wdata_st;
              ld_code_q <= ld_code;
              off_q     <= addr[1:0];
              is_ld_q   <= ld_en;
            end
          end
        end
        REQ: begin
          if (bus.ack) begin
            state   <= DONE;
            bus.req <= 1'b0;
            if (is_ld_q) begin
              rdata       <= ld_data;
              rdata_valid <= 1'b1;
            end
          end else if (timeout_hit) begin
            state   <= DONE;
            bus.req <= 1'b0;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: a transaction-level model sets per-cycle
// expectations that a negedge compare process checks against the DUT.
module tb_lsu_bus_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_code = 3'd0;
  logic [1:0]  st_code = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;

  lsu_bus_ctrl_if #(.XLEN(32)) bus ();

  lsu_bus_ctrl #(.TIMEOUT(TO), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_en       (ld_en),
    .ld_code     (ld_code),
    .st_code     (st_code),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_rv = 1'b0, exp_err = 1'b0;
  logic        exp_we = 1'b0, exp_chk_wd = 1'b0;
  logic [31:0] exp_addr = 32'd0, exp_be = 32'd0, exp_wdata = 32'd0, exp_rdata = 32'd0;
  int          stall_cnt, req_cnt;
  logic [31:0] seen_be, seen_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes as implied by the decoder codes.
  function automatic int acc_size(input logic ld, input logic [2:0] lc, input logic [1:0] sc);
    if (ld) return (lc == 3'd2 || lc == 3'd4) ? 1 : (lc == 3'd3 || lc == 3'd5) ? 2 : 4;
    return (sc == 2'd1) ? 1 : (sc == 2'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] lc, input int off, input logic [31:0] rw);
    logic [31:0] v;
    int sz;
    sz = acc_size(1'b1, lc, 2'd0);
    v  = rw >> (8 * off);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (lc == 3'd2 && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (lc == 3'd3 && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("bus_req", 32'(bus.req), 32'(exp_req));
      chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
      chk("err", 32'(err), 32'(exp_err));
      chk("rdata", rdata, exp_rdata);
      if (exp_req) begin
        chk("bus_addr", bus.addr, exp_addr);
        chk("bus_we", 32'(bus.we), 32'(exp_we));
        chk("bus_be", 32'(bus.be), exp_be);
        if (exp_chk_wd) chk("bus_wdata", bus.wdata, exp_wdata);
      end
    end
  end

  // One instruction: ack_at = REQ cycle carrying ack (0 = never acknowledge).
  task automatic run(input logic ld, input logic [2:0] lc, input logic [1:0] sc,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                     input int ack_at);
    int  sz, off, nreq;
    bit  legal, ok;
    sz    = acc_size(ld, lc, sc);
    off   = int'(a % 4);
    legal = !(ld && sc != 2'd0) && ((a % sz) == 0);
    ok    = legal && ack_at >= 1 && ack_at <= int'(TO);
    nreq  = !legal ? 0 : ok ? ack_at : int'(TO);
    stall_cnt = 0;
    req_cnt   = 0;
    for (int c = 0; c <= nreq + 1; c++) begin
      @(posedge clk); #1;
      ld_en = ld; ld_code = lc; st_code = sc; addr = a; wdata = wd;
      bus.rdata  = rw;
      bus.ack    = (c >= 1 && c <= nreq && c == ack_at);
      exp_stall  = (c <= nreq);
      exp_req    = (c >= 1 && c <= nreq);
      exp_err    = (c == nreq + 1) && !ok;
      exp_rv     = (c == nreq + 1) && ok && ld;
      exp_addr   = a & ~32'h3;
      exp_we     = !ld;
      exp_be     = ld ? 32'hF : (((32'd1 << sz) - 1) << off);
      exp_wdata  = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
                   (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      exp_chk_wd = !ld;
      if (exp_rv) exp_rdata = model_load(lc, off, rw);
      @(negedge clk);
      if (stall) stall_cnt++;
      if (bus.req) begin
        req_cnt++;
        seen_be    = 32'(bus.be);
        seen_wdata = bus.wdata;
      end
    end
    @(posedge clk); #1;
    ld_en = 1'b0; st_code = 2'd0; bus.ack = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_rv = 1'b0;
  endtask

  initial begin
    bus.ack   = 1'b0;
    bus.rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bus_req", 32'(bus.req), 32'd0);
    chk("rst_bus_addr", bus.addr, 32'd0);
    chk("rst_bus_be", 32'(bus.be), 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    run(1'b0, 3'd0, 2'd3, 32'h100, 32'hDEADBEEF, 32'd0, 3);
    chk("sw_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("sw_be_lit", seen_be, 32'hF);

    run(1'b0, 3'd0, 2'd1, 32'h103, 32'h000000A5, 32'd0, 1);
    chk("sb_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("sb_be_lit", seen_be, 32'h8);
    chk("sb_wdata_lit", seen_wdata, 32'hA5A5A5A5);

    run(1'b1, 3'd2, 2'd0, 32'h202, 32'd0, 32'h12F45678, 1);
    chk("lb_lit", rdata, 32'hFFFFFFF4);
    run(1'b1, 3'd4, 2'd0, 32'h202, 32'd0, 32'h12F45678, 1);
    chk("lbu_lit", rdata, 32'h000000F4);
    run(1'b1, 3'd5, 2'd0, 32'h202, 32'd0, 32'h12F45678, 1);
    chk("lhu_lit", rdata, 32'h000012F4);

    run(1'b1, 3'd3, 2'd0, 32'h201, 32'd0, 32'h12F45678, 1);
    chk("lh_mis_stall_cycles", 32'(stall_cnt), 32'd1);
    chk("lh_mis_req_cycles", 32'(req_cnt), 32'd0);
    chk("lh_mis_rdata_lit", rdata, 32'h000012F4);

    run(1'b1, 3'd1, 2'd0, 32'h40, 32'd0, 32'h55555555, 0);
    chk("timeout_req_cycles", 32'(req_cnt), 32'd4);

    run(1'b1, 3'd1, 2'd3, 32'h80, 32'h1, 32'h0, 1);
    chk("conflict_req_cycles", 32'(req_cnt), 32'd0);

    run(1'b0, 3'd0, 2'd2, 32'h102, 32'h1234BEEF, 32'd0, 2);
    chk("sh_be_lit", seen_be, 32'hC);
    chk("sh_wdata_lit", seen_wdata, 32'hBEEFBEEF);

    run(1'b1, 3'd3, 2'd0, 32'h206, 32'd0, 32'h80017FFF, 2);
    chk("lh_lit", rdata, 32'hFFFF8001);

    run(1'b0, 3'd0, 2'd3, 32'h101, 32'h12345678, 32'd0, 1);

    // Reset in the second REQ cycle of a store.
    chk_en = 1'b0;
    @(posedge clk); #1;
    st_code = 2'd3; addr = 32'h300; wdata = 32'h11223344; ld_en = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(bus.req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid_rst_req", 32'(bus.req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    st_code = 2'd0;
    @(posedge clk); #1;
    rst       = 1'b0;
    exp_rdata = 32'd0;
    chk_en    = 1'b1;

    run(1'b1, 3'd1, 2'd0, 32'h10, 32'd0, 32'hCAFEF00D, 1);
    chk("post_rst_lw_lit", rdata, 32'hCAFEF00D);

    run(1'b1, 3'd7, 2'd0, 32'h20, 32'd0, 32'h0BADF00D, 1);
    chk("code7_lw_lit", rdata, 32'h0BADF00D);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
